// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and a saturating add
// reused by any counter that must stick at its maximum.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  // Returns a + b clamped to max_val; the 33-bit sum keeps the carry visible.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One payload register of a pipeline stage: load-enabled flop with an
// asynchronous reset value.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // NOTE: the payload is reset (not left X) because out_data must read RST_VAL
  // straight out of reset; non-blocking <= keeps every flop sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with optional skid entry, synchronous flush and a
// saturating count of entries discarded by flush.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 16,
  parameter int                SKID    = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter int                ZERO_FL = 1,
  parameter int                CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                  : 32'((64'd1 << CNT_W) - 64'd1);

  occ_e              state_q, state_d;
  logic              accept, emit;
  logic              main_load, skid_load;
  logic [DATA_W-1:0] main_d, main_q, skid_q;
  logic [CNT_W-1:0]  drop_q;
  logic [31:0]       drop_inc;

  assign out_valid = (state_q != ST_EMPTY);
  // With a skid entry in_ready depends only on registered state; without one it
  // must look at out_ready to sustain one item per cycle.
  assign in_ready  = (SKID != 0) ? (state_q != ST_FULL) : (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign occupancy = state_q;
  assign out_data  = main_q;
  assign drop_cnt  = drop_q;

  // NOTE: every output of this block gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_data;
    drop_inc  = '0;
    if (flush) begin
      state_d   = ST_EMPTY;
      main_load = (ZERO_FL != 0);
      main_d    = RST_VAL;
      // An entry emitted in the flush cycle was delivered, so it is not a drop.
      drop_inc  = 32'(state_q) + 32'(accept) - 32'(emit);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        drop_q <= CNT_W'(sat_add(32'(drop_q), drop_inc, CNT_MAX));
      end
    end
  end

  pipe_entry #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (skid_load),
      .d    (in_data),
      .q    (skid_q)
    );
  end else begin : g_no_skid
    assign skid_q = '0;
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: skid stage (u_a), narrow-counter stage (u_b)
// and single-entry stage (u_c), all with hand-computed expectations.
module tb_pipe_stage_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [7:0]  a_drop;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [1:0]  b_drop;

  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [15:0] c_in_data, c_out_data;
  logic [1:0]  c_occ;
  logic [7:0]  c_drop;

  pipe_stage_hs #(.DATA_W(16), .SKID(1), .RST_VAL(16'hDEAD), .ZERO_FL(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .occupancy(a_occ), .drop_cnt(a_drop)
  );

  pipe_stage_hs #(.DATA_W(16), .SKID(1), .RST_VAL(16'h0000), .ZERO_FL(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .occupancy(b_occ), .drop_cnt(b_drop)
  );

  pipe_stage_hs #(.DATA_W(16), .SKID(0), .RST_VAL(16'h0000), .ZERO_FL(1), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .occupancy(c_occ), .drop_cnt(c_drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the next falling edge (output sample point).
  task automatic smp();
    @(negedge clk);
  endtask

  logic        m_valid;
  logic        exp_ready;
  logic [15:0] m_data, send, want;
  int          n_acc, n_emit;
  int          exp5 [3] = '{2, 3, 3};

  initial begin
    {a_flush, a_in_valid, a_out_ready, a_in_data} = '0;
    {b_flush, b_in_valid, b_out_ready, b_in_data} = '0;
    {c_flush, c_in_valid, c_out_ready, c_in_data} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: reset while holding two entries
    cyc(); a_in_valid = 1'b1; a_in_data = 16'h0001;
    cyc(); a_in_data = 16'h0002;
    cyc(); a_in_valid = 1'b0;
    smp();
    check("t1_occ_before_rst", 32'(a_occ), 2);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_occ", 32'(a_occ), 0);
    check("t1_rst_valid", 32'(a_out_valid), 0);
    check("t1_rst_data", 32'(a_out_data), 32'hDEAD);
    check("t1_rst_in_ready", 32'(a_in_ready), 1);
    check("t1_rst_drop", 32'(a_drop), 0);
    #1 rst = 1'b0;

    // 2: full-throughput stream 0x0001..0x0010
    a_out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      a_in_valid = (i <= 16);
      a_in_data  = 16'(i);
      smp();
      if (i >= 2) begin
        check("t2_data", 32'(a_out_data), 32'(i - 1));
        check("t2_valid", 32'(a_out_valid), 1);
        check("t2_occ", 32'(a_occ), 1);
      end
    end
    cyc(); smp();
    check("t2_drained", 32'(a_out_valid), 0);

    // 3: fill skid with downstream stalled, then release
    cyc(); a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'hAAAA;
    cyc(); a_in_data = 16'hBBBB;
    cyc(); a_in_data = 16'hCCCC;
    smp();
    check("t3_occ_full", 32'(a_occ), 2);
    check("t3_in_ready", 32'(a_in_ready), 0);
    check("t3_head", 32'(a_out_data), 32'hAAAA);
    cyc(); smp();
    check("t3_hold_occ", 32'(a_occ), 2);
    check("t3_hold_data", 32'(a_out_data), 32'hAAAA);
    a_out_ready = 1'b1;
    smp();
    check("t3_second", 32'(a_out_data), 32'hBBBB);
    check("t3_occ_one", 32'(a_occ), 1);
    check("t3_ready_back", 32'(a_in_ready), 1);
    cyc(); a_in_valid = 1'b0;
    smp();
    check("t3_third", 32'(a_out_data), 32'hCCCC);
    check("t3_third_valid", 32'(a_out_valid), 1);
    cyc(); smp();
    check("t3_drained", 32'(a_out_valid), 0);

    // 4: flush accounting
    cyc(); a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h5555;
    cyc(); a_in_valid = 1'b0; a_flush = 1'b1;
    cyc(); a_flush = 1'b0;
    smp();
    check("t4_drop_one", 32'(a_drop), 1);
    check("t4_zero_fl_data", 32'(a_out_data), 32'hDEAD);
    a_in_valid = 1'b1; a_in_data = 16'h0AAA;
    cyc(); a_in_data = 16'h0BBB;
    cyc(); a_in_data = 16'h1234; a_flush = 1'b1;
    smp();
    check("t4_full_before_flush", 32'(a_occ), 2);
    check("t4_1234_held_off", 32'(a_in_ready), 0);
    cyc(); a_flush = 1'b0; a_in_valid = 1'b0;
    smp();
    check("t4_flush_valid", 32'(a_out_valid), 0);
    check("t4_flush_occ", 32'(a_occ), 0);
    check("t4_drop_three", 32'(a_drop), 3);
    check("t4_flush_data", 32'(a_out_data), 32'hDEAD);
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      check("t4_1234_never_emitted", 32'(a_out_valid), 0);
    end
    cyc(); a_flush = 1'b1;
    cyc(); a_flush = 1'b0;
    smp();
    check("t4_empty_flush", 32'(a_drop), 3);
    a_in_valid = 1'b1; a_in_data = 16'h7777;
    cyc(); a_in_valid = 1'b0; a_flush = 1'b1;
    smp();
    check("t4_emit_in_flush", 32'(a_out_data), 32'h7777);
    cyc(); a_flush = 1'b0;
    smp();
    check("t4_emit_not_dropped", 32'(a_drop), 3);
    a_in_valid = 1'b1; a_in_data = 16'h1111; a_flush = 1'b1;
    cyc(); a_flush = 1'b0; a_in_valid = 1'b0;
    smp();
    check("t4_accept_dropped", 32'(a_drop), 4);
    check("t4_accept_not_kept", 32'(a_out_valid), 0);

    // 5: two-bit drop counter saturates; ZERO_FL=0 keeps the old payload
    for (int r = 0; r < 3; r++) begin
      cyc(); b_in_valid = 1'b1; b_in_data = 16'(16'h0011 + r);
      cyc(); b_in_data = 16'(16'h0111 + r);
      cyc(); b_in_valid = 1'b0; b_flush = 1'b1;
      cyc(); b_flush = 1'b0;
      smp();
      check("t5_drop_sat", 32'(b_drop), 32'(exp5[r]));
      check("t5_valid", 32'(b_out_valid), 0);
      check("t5_data_kept", 32'(b_out_data), 32'(16'h0011 + r));
    end

    // 6: single-entry stage with toggling out_ready
    m_valid = 1'b0; m_data = '0; send = 16'h0101; want = 16'h0101;
    n_acc = 0; n_emit = 0;
    for (int k = 0; k < 9; k++) begin
      cyc();
      c_out_ready = (k >= 6) || (k % 2 == 0);
      c_in_valid  = (k < 6);
      c_in_data   = send;
      smp();
      exp_ready = ~m_valid | c_out_ready;
      check("t6_in_ready", 32'(c_in_ready), 32'(exp_ready));
      check("t6_out_valid", 32'(c_out_valid), 32'(m_valid));
      if (m_valid) check("t6_out_data", 32'(c_out_data), 32'(m_data));
      if (m_valid && c_out_ready) begin
        check("t6_order", 32'(c_out_data), 32'(want));
        want++;
        n_emit++;
      end
      if (c_in_valid && exp_ready) begin
        m_valid = 1'b1; m_data = send; send++; n_acc++;
      end else if (m_valid && c_out_ready) begin
        m_valid = 1'b0;
      end
    end
    check("t6_no_loss", 32'(n_emit), 32'(n_acc));
    check("t6_accepted", 32'(n_acc), 3);
    check("t6_final_occ", 32'(c_occ), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
